// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C / host memory arbiter.
//   state_t              : arbiter FSM state encoding
//   STARVE_LIMIT_DEFAULT : default number of back-to-back I2C grants allowed
//                          while the host is waiting (legal range 1..15)
package i2c_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACC_I2C,
        ACC_HOST,
        RESP_I2C,
        RESP_HOST
    } state_t;

endpackage

// File: rtl/i2c_mem_arbiter_if.sv
// Requester-side access port of the memory arbiter, one instance per requester.
//   req/we/addr/wdata : access request, driven by the requester
//   gnt               : one-cycle pulse, access issued to memory
//   valid             : one-cycle pulse, access complete
//   rdata             : read data, valid with valid on reads, held until next valid
// Modports: master = requester side, slave = arbiter side.
interface i2c_mem_arbiter_if;

    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       gnt;
    logic       valid;
    logic [7:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, valid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, valid, rdata);

endinterface

// File: rtl/i2c_arb_prio.sv
// Winner selection and anti-starvation streak counter.
//   clk, reset : system clock, synchronous active-high reset
//   idle       : arbiter FSM is in IDLE (requests only considered then)
//   i2c_req    : I2C-side request
//   host_req   : host-side request
//   pick_i2c   : I2C wins this IDLE cycle
//   pick_host  : host wins this IDLE cycle
// I2C normally wins; after STARVE_LIMIT consecutive I2C grants with the host
// waiting, the host is given the next slot.
module i2c_arb_prio
    import i2c_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic i2c_req,
    input  logic host_req,
    output logic pick_i2c,
    output logic pick_host
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak;
    logic       starved;

    always_comb begin
        starved   = host_req && (streak == LIMIT);
        pick_i2c  = idle && i2c_req && !starved;
        pick_host = idle && host_req && !pick_i2c;
    end

    // Counted at the decision edge, which is the same edge the grant is issued from.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (idle) begin
            if (pick_host || !host_req) begin
                streak <= '0;
            end else if (pick_i2c && (streak != LIMIT)) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_mem_arbiter.sv
// Arbitrates a single-port synchronous memory between an I2C slave and a local host.
//   clk, reset : system clock, synchronous active-high reset
//   i2c        : I2C requester port (slave modport)
//   host       : host requester port (slave modport)
//   mem_addr   : memory address (holds last latched value outside accesses)
//   mem_wdata  : memory write data (holds last latched value outside accesses)
//   mem_we     : memory write strobe, only in an access cycle
//   mem_rdata  : memory read data, one cycle after the access cycle
// Each access: IDLE -> ACC_x (gnt) -> RESP_x (valid) -> IDLE.
module i2c_mem_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    i2c_mem_arbiter_if.slave    i2c,
    i2c_mem_arbiter_if.slave    host,
    output logic [7:0]          mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                mem_we,
    input  logic [7:0]          mem_rdata
);

    state_t     state, state_nx;
    logic       pick_i2c, pick_host;
    logic       lat_we;
    logic [7:0] lat_addr, lat_wdata;
    logic [7:0] i2c_rdata_q, host_rdata_q;

    i2c_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .reset     (reset),
        .idle      (state == IDLE),
        .i2c_req   (i2c.req),
        .host_req  (host.req),
        .pick_i2c  (pick_i2c),
        .pick_host (pick_host)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE: begin
                if (pick_i2c) begin
                    state_nx = ACC_I2C;
                end else if (pick_host) begin
                    state_nx = ACC_HOST;
                end else begin
                    state_nx = IDLE;
                end
            end
            ACC_I2C:   state_nx = RESP_I2C;
            ACC_HOST:  state_nx = RESP_HOST;
            RESP_I2C:  state_nx = IDLE;
            RESP_HOST: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Winner's request captured on the IDLE -> ACC edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (pick_i2c) begin
            lat_we    <= i2c.we;
            lat_addr  <= i2c.addr;
            lat_wdata <= i2c.wdata;
        end else if (pick_host) begin
            lat_we    <= host.we;
            lat_addr  <= host.addr;
            lat_wdata <= host.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (state == RESP_I2C && !lat_we) begin
                i2c_rdata_q <= mem_rdata;
            end
            if (state == RESP_HOST && !lat_we) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data is forwarded straight from memory during RESP so it is
    // valid alongside the valid pulse; the register holds it afterwards.
    always_comb begin
        i2c.gnt    = (state == ACC_I2C);
        host.gnt   = (state == ACC_HOST);
        i2c.valid  = (state == RESP_I2C);
        host.valid = (state == RESP_HOST);
        mem_we     = ((state == ACC_I2C) || (state == ACC_HOST)) && lat_we;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        i2c.rdata  = (state == RESP_I2C && !lat_we) ? mem_rdata : i2c_rdata_q;
        host.rdata = (state == RESP_HOST && !lat_we) ? mem_rdata : host_rdata_q;
    end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Self-checking bench for i2c_mem_arbiter: directed scenarios plus random
// mixed traffic checked against a transaction-level model.
module tb_i2c_mem_arbiter;

    localparam int LIMIT = 8;
    localparam int BOUND = (LIMIT + 1) * 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    i2c_mem_arbiter_if i2c_bus ();
    i2c_mem_arbiter_if host_bus ();

    i2c_mem_arbiter #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c       (i2c_bus),
        .host      (host_bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory with a bench-side preload port.
    logic [7:0] mem [256];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic set_req(input logic to_host, input logic req, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (to_host) begin
            host_bus.req = req; host_bus.we = we; host_bus.addr = addr; host_bus.wdata = wdata;
        end else begin
            i2c_bus.req = req; i2c_bus.we = we; i2c_bus.addr = addr; i2c_bus.wdata = wdata;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_en   = 1'b1;
            pre_addr = 8'(i);
            pre_data = 8'($urandom);
            ref_mem[i] = pre_data;
            @(negedge clk);
        end
        pre_en = 1'b0;
        n_tests++;
        if ({i2c_bus.gnt, host_bus.gnt, i2c_bus.valid, host_bus.valid, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got gnt=%b%b valid=%b%b we=%b want all 0",
                     i2c_bus.gnt, host_bus.gnt, i2c_bus.valid, host_bus.valid, mem_we);
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h want 00 00", mem_addr, mem_wdata);
        end
        n_tests++;
        if ({i2c_bus.rdata, host_bus.rdata} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got i2c=%h host=%h want 00 00", i2c_bus.rdata, host_bus.rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.gnt, host_bus.gnt, i2c_bus.valid, host_bus.valid, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle got nonzero strobes want all 0");
        end
    endtask

    task automatic test_host_rw();
        int we_cycles = 0;
        set_req(1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        if (mem_we) we_cycles++;
        n_tests++;
        if ({host_bus.gnt, i2c_bus.gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 8'h10, 8'hA5}) begin
            n_fail++;
            $display("FAIL host_wr_issue got gnt=%b we=%b addr=%h wdata=%h want gnt=1 we=1 addr=10 wdata=a5",
                     host_bus.gnt, mem_we, mem_addr, mem_wdata);
        end
        set_req(1'b1, 1'b0, 1'b0, 8'h10, 8'hA5);
        ref_mem[8'h10] = 8'hA5;
        @(negedge clk);
        if (mem_we) we_cycles++;
        n_tests++;
        if ({host_bus.valid, host_bus.gnt, mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL host_wr_valid got valid=%b gnt=%b we=%b want 1 0 0", host_bus.valid, host_bus.gnt, mem_we);
        end
        @(negedge clk);
        if (mem_we) we_cycles++;
        n_tests++;
        if (we_cycles != 1) begin
            n_fail++;
            $display("FAIL host_wr_we_width got %0d cycles want 1", we_cycles);
        end
        set_req(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        n_tests++;
        if ({host_bus.gnt, mem_we, mem_addr} !== {2'b10, 8'h10}) begin
            n_fail++;
            $display("FAIL host_rd_issue got gnt=%b we=%b addr=%h want 1 0 10", host_bus.gnt, mem_we, mem_addr);
        end
        set_req(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        n_tests++;
        if ({host_bus.valid, host_bus.rdata} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL host_rd_data got valid=%b rdata=%h want 1 a5", host_bus.valid, host_bus.rdata);
        end
        @(negedge clk);
        n_tests++;
        if ({host_bus.valid, host_bus.rdata} !== {1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL host_rd_hold got valid=%b rdata=%h want 0 a5", host_bus.valid, host_bus.rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] ra, wa, wd;
        ra = 8'($urandom);
        wa = 8'($urandom);
        wd = 8'($urandom);
        set_req(1'b0, 1'b1, 1'b0, ra, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, wa, wd);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.gnt, host_bus.gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL simul_first got i2c_gnt=%b host_gnt=%b want 1 0", i2c_bus.gnt, host_bus.gnt);
        end
        set_req(1'b0, 1'b0, 1'b0, ra, 8'h00);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.valid, i2c_bus.rdata} !== {1'b1, ref_mem[ra]}) begin
            n_fail++;
            $display("FAIL simul_i2c_rd got valid=%b rdata=%h want 1 %h", i2c_bus.valid, i2c_bus.rdata, ref_mem[ra]);
        end
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.gnt, host_bus.gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_idle got gnt=%b%b want 00", i2c_bus.gnt, host_bus.gnt);
        end
        @(negedge clk);
        n_tests++;
        if ({host_bus.gnt, i2c_bus.gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, wa, wd}) begin
            n_fail++;
            $display("FAIL simul_second got host_gnt=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                     host_bus.gnt, mem_we, mem_addr, mem_wdata, wa, wd);
        end
        set_req(1'b1, 1'b0, 1'b0, wa, wd);
        ref_mem[wa] = wd;
        @(negedge clk);
        n_tests++;
        if (host_bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_host_valid got %b want 1", host_bus.valid);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int order[$];
        int cycles = 0;
        set_req(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        while (order.size() < 2 * (LIMIT + 1) && cycles < 4 * (LIMIT + 1) * 3) begin
            @(negedge clk);
            cycles++;
            if (i2c_bus.gnt) order.push_back(0);
            if (host_bus.gnt) order.push_back(1);
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h01, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        n_tests++;
        if (order.size() != 2 * (LIMIT + 1)) begin
            n_fail++;
            $display("FAIL starve_count got %0d grants want %0d", order.size(), 2 * (LIMIT + 1));
        end
        foreach (order[k]) begin
            n_tests++;
            if (order[k] != ((k % (LIMIT + 1) == LIMIT) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL starve_order grant %0d got %s want %s", k, order[k] ? "host" : "i2c",
                         (k % (LIMIT + 1) == LIMIT) ? "host" : "i2c");
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        set_req(1'b0, 1'b1, 1'b1, 8'h55, 8'h99);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.gnt, mem_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_issue got gnt=%b we=%b want 1 1", i2c_bus.gnt, mem_we);
        end
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h55, 8'h99);
        ref_mem[8'h55] = 8'h99;
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.valid, host_bus.valid, i2c_bus.gnt, host_bus.gnt, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_strobes got valid=%b gnt=%b we=%b want all 0", i2c_bus.valid, i2c_bus.gnt, mem_we);
        end
        n_tests++;
        if ({mem_addr, mem_wdata, i2c_bus.rdata, host_bus.rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_values got addr=%h wdata=%h rdata=%h/%h want zeros",
                     mem_addr, mem_wdata, i2c_bus.rdata, host_bus.rdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({i2c_bus.valid, host_bus.valid, i2c_bus.gnt, host_bus.gnt, mem_we} !== 5'b0) begin
                n_fail++;
                $display("FAIL abort_after cycle %0d got nonzero strobes want all 0", i);
            end
        end
    endtask

    task automatic test_interleave();
        pre_en = 1'b1; pre_addr = 8'h20; pre_data = 8'h3C;
        ref_mem[8'h20] = 8'h3C;
        @(negedge clk);
        pre_en = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'h20, 8'h77);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.gnt, host_bus.gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL inter_first got i2c_gnt=%b host_gnt=%b want 1 0", i2c_bus.gnt, host_bus.gnt);
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.valid, i2c_bus.rdata} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL inter_rd_old got valid=%b rdata=%h want 1 3c", i2c_bus.valid, i2c_bus.rdata);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({host_bus.gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h20, 8'h77}) begin
            n_fail++;
            $display("FAIL inter_host_wr got gnt=%b we=%b addr=%h wdata=%h want 1 1 20 77",
                     host_bus.gnt, mem_we, mem_addr, mem_wdata);
        end
        set_req(1'b1, 1'b0, 1'b0, 8'h20, 8'h77);
        ref_mem[8'h20] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        n_tests++;
        if ({i2c_bus.valid, i2c_bus.rdata} !== {1'b1, 8'h77}) begin
            n_fail++;
            $display("FAIL inter_rd_new got valid=%b rdata=%h want 1 77", i2c_bus.valid, i2c_bus.rdata);
        end
        @(negedge clk);
    endtask

    // Transaction-level model: I2C wins unless the host has waited through
    // LIMIT consecutive I2C grants.
    task automatic test_random();
        logic       pend[2], is_we[2], want_valid[2], want_read[2], late[2], g[2], v[2];
        logic [7:0] ad[2], wd[2], want_rd[2], rd[2];
        int         since[2];
        int         starve = 0;
        int         w;
        logic       exp_host;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; is_we[k] = 0; want_valid[k] = 0; want_read[k] = 0; late[k] = 0;
            ad[k] = '0; wd[k] = '0; want_rd[k] = '0; since[k] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            g[0] = i2c_bus.gnt;   g[1] = host_bus.gnt;
            v[0] = i2c_bus.valid; v[1] = host_bus.valid;
            rd[0] = i2c_bus.rdata; rd[1] = host_bus.rdata;
            for (int k = 0; k < 2; k++) if (pend[k]) since[k]++;
            n_tests++;
            if ((g[0] && g[1]) || (v[0] && v[1])) begin
                n_fail++;
                $display("FAIL rand_one_hot cycle %0d got gnt=%b%b valid=%b%b want at most one each",
                         cyc, g[0], g[1], v[0], v[1]);
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (v[k] !== want_valid[k]) begin
                    n_fail++;
                    $display("FAIL rand_valid port %0d cycle %0d got %b want %b", k, cyc, v[k], want_valid[k]);
                end
                if (v[k] && want_read[k]) begin
                    n_tests++;
                    if (rd[k] !== want_rd[k]) begin
                        n_fail++;
                        $display("FAIL rand_rdata port %0d cycle %0d got %h want %h", k, cyc, rd[k], want_rd[k]);
                    end
                end
                want_valid[k] = 0;
            end
            if (g[0] || g[1]) begin
                n_tests++;
                if (!pend[0] && !pend[1]) begin
                    n_fail++;
                    $display("FAIL rand_spurious_gnt cycle %0d got gnt=%b%b want none", cyc, g[0], g[1]);
                end else begin
                    exp_host = !pend[0] || (pend[1] && starve == LIMIT);
                    if ({g[0], g[1]} !== {!exp_host, exp_host}) begin
                        n_fail++;
                        $display("FAIL rand_arb cycle %0d got gnt=%b%b want %b%b", cyc, g[0], g[1], !exp_host, exp_host);
                    end
                    w = exp_host ? 1 : 0;
                    if (exp_host || !pend[1]) starve = 0;
                    else if (starve < LIMIT) starve++;
                    n_tests++;
                    if (since[w] > BOUND) begin
                        n_fail++;
                        $display("FAIL rand_latency port %0d got %0d cycles want <= %0d", w, since[w], BOUND);
                    end
                    n_tests++;
                    if ({mem_we, mem_addr} !== {is_we[w], ad[w]} || (is_we[w] && mem_wdata !== wd[w])) begin
                        n_fail++;
                        $display("FAIL rand_mem_issue cycle %0d got we=%b addr=%h wdata=%h want %b %h %h",
                                 cyc, mem_we, mem_addr, mem_wdata, is_we[w], ad[w], wd[w]);
                    end
                    if (is_we[w]) begin
                        ref_mem[ad[w]] = wd[w];
                        want_read[w] = 0;
                    end else begin
                        want_read[w] = 1;
                        want_rd[w] = ref_mem[ad[w]];
                    end
                    want_valid[w] = 1;
                    pend[w] = 0;
                    late[w] = 0;
                    set_req(w == 1, 1'b0, is_we[w], ad[w], wd[w]);
                end
            end else begin
                n_tests++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_we_outside_acc cycle %0d got %b want 0", cyc, mem_we);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (pend[k] && !late[k]) begin
                    n_tests++;
                    if (since[k] > BOUND) begin
                        n_fail++;
                        late[k] = 1;
                        $display("FAIL rand_starved port %0d waited %0d cycles want <= %0d", k, since[k], BOUND);
                    end
                end
            end
            if (cyc < 1950) begin
                for (int k = 0; k < 2; k++) begin
                    if (!pend[k] && !want_valid[k] && int'($urandom_range(0, 99)) < (k == 0 ? 75 : 30)) begin
                        pend[k]  = 1;
                        is_we[k] = 1'($urandom);
                        ad[k]    = 8'($urandom_range(0, 15));
                        wd[k]    = 8'($urandom);
                        since[k] = 0;
                        set_req(k == 1, 1'b1, is_we[k], ad[k], wd[k]);
                    end
                end
            end
        end
        n_tests++;
        if (pend[0] || pend[1] || want_valid[0] || want_valid[1]) begin
            n_fail++;
            $display("FAIL rand_drain got pending=%b%b want 00", pend[0], pend[1]);
        end
    endtask

    initial begin
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        test_reset();
        test_host_rw();
        test_simultaneous();
        test_starvation();
        test_reset_abort();
        test_interleave();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
